step_pulse_gen: RTL and testbench

//   Upstream conditioner for the 3-phase ring-counter stage: turns the raw, bouncy

---
 rtl/step_pulse_gen.sv | 161 ++++++++++++++++
 tb/tb_step_pulse_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// ---------------------------------------------------------------------------
// step_pulse_gen
//   Conditions the raw step button for the 3-phase ring-counter stage.
//   The asynchronous button level is synchronised, debounced on both press
//   and release, and turned into single-cycle step strobes: one per accepted
//   press, plus optional auto-repeat strobes while the button stays held.
//   A wrapping 8-bit count of issued strobes is kept for debug readout.
//
// Parameters
//   SYNC_STAGES      synchroniser depth on btn_in (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable samples to accept a press/release (>= 2)
//   REPEAT_DELAY     held cycles before the first auto-repeat strobe (>= 2)
//   REPEAT_PERIOD    cycles between later auto-repeat strobes (>= 2)
//
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous reset, active-high
//   btn_in      in   1  raw asynchronous button level, 1 = pressed
//   repeat_en   in   1  1 = auto-repeat allowed while held
//   step_pulse  out  1  one-cycle strobe per accepted step
//   btn_level   out  1  debounced button level
//   step_count  out  8  number of step_pulse strobes issued, mod 256
// ---------------------------------------------------------------------------
module step_pulse_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_PERIOD   = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       repeat_en,
    output logic       step_pulse,
    output logic       btn_level,
    output logic [7:0] step_count
);

    // The shared counter only ever needs to reach (largest parameter - 1).
    localparam int CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        HELD,
        REPEAT,
        DB_RELEASE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;

    assign btn_s = sync[SYNC_STAGES-1];

    // NOTE: all state here is written with non-blocking assignments so every
    // register samples the values from before the edge; mixing in blocking
    // writes would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= '0;
            state      <= IDLE;
            cnt        <= '0;
            step_pulse <= 1'b0;
            btn_level  <= 1'b0;
            step_count <= '0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], btn_in};
            step_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    btn_level <= 1'b0;
                    if (btn_s) begin
                        state <= DB_PRESS;
                        cnt   <= '0;
                    end
                end

                DB_PRESS: begin
                    if (!btn_s) begin
                        // Bounce: drop back without issuing anything.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state      <= HELD;
                        cnt        <= '0;
                        btn_level  <= 1'b1;
                        step_pulse <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                HELD: begin
                    btn_level <= 1'b1;
                    if (!btn_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (!repeat_en) begin
                        // Repeat delay only accumulates while repeat is allowed.
                        cnt <= '0;
                    end else if (cnt == DELAY_LAST) begin
                        state      <= REPEAT;
                        cnt        <= '0;
                        step_pulse <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                REPEAT: begin
                    if (!btn_s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (!repeat_en) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == PERIOD_LAST) begin
                        cnt        <= '0;
                        step_pulse <= 1'b1;
                        step_count <= step_count + 8'd1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DB_RELEASE: begin
                    // Level stays high until the release is confirmed.
                    if (btn_s) begin
                        // Release bounce: back to HELD, repeat delay restarts.
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_step_pulse_gen
//   Directed bench for step_pulse_gen with SYNC=2, DEB=4, DELAY=8, PERIOD=4.
//   Stimulus pushes the expected (edge number, step_count) of every strobe it
//   provokes; a negedge monitor pops and compares each strobe the DUT issues.
// ---------------------------------------------------------------------------
module tb_step_pulse_gen;

    localparam int SYNC   = 2;
    localparam int DEB    = 4;
    localparam int DELAY  = 8;
    localparam int PERIOD = 4;
    // Edge (counted from the driving negedge) after which the strobe is high.
    localparam int LAT    = SYNC + DEB + 1;

    typedef struct {
        int         cyc;
        logic [7:0] count;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       btn_in;
    logic       repeat_en;
    logic       step_pulse;
    logic       btn_level;
    logic [7:0] step_count;

    int         cyc;
    int         checks;
    int         errors;
    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] exp_count;
    logic       prev_pulse;

    step_pulse_gen #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .repeat_en (repeat_en),
        .step_pulse(step_pulse),
        .btn_level (btn_level),
        .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at_cyc);
        exp_t e;
        exp_count = exp_count + 8'd1;
        e.cyc     = at_cyc;
        e.count   = exp_count;
        q.push_back(e);
    endtask

    // Strobe monitor: every strobe must be expected, on time, with the right count.
    initial prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            check("back_to_back", prev_pulse, 0);
            check("pulse_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                check("pulse_cycle", cyc, mon_e.cyc);
                check("pulse_count", step_count, mon_e.count);
            end
        end
        prev_pulse = step_pulse;
    end

    initial begin
        int d;
        int e;
        checks    = 0;
        errors    = 0;
        exp_count = 8'd0;
        rst       = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        tick(3);
        check("rst_pulse", step_pulse, 0);
        check("rst_level", btn_level, 0);
        check("rst_count", step_count, 0);
        rst = 1'b0;
        tick(2);

        // 1: clean press, strobe after edge 7, level rises with it.
        d = cyc;
        btn_in = 1'b1;
        push(d + LAT);
        tick(LAT - 1);
        check("t1_level_before", btn_level, 0);
        tick(1);
        check("t1_level", btn_level, 1);
        check("t1_count", step_count, 1);
        tick(1);
        check("t1_single", step_pulse, 0);
        tick(5);
        btn_in = 1'b0;
        tick(LAT + 1);
        check("t1_release", btn_level, 0);
        check("t1_pending", q.size(), 0);

        // 2: press shorter than the debounce window is rejected.
        btn_in = 1'b1;
        tick(3);
        btn_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t2_level", btn_level, 0);
        end
        check("t2_count", step_count, 1);

        // 3: release bounce keeps the level; clean release drops it after DEB samples.
        d = cyc;
        btn_in = 1'b1;
        push(d + LAT);
        tick(LAT + 3);
        btn_in = 1'b0;
        tick(2);
        btn_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("t3_level_held", btn_level, 1);
        end
        d = cyc;
        btn_in = 1'b0;
        tick(LAT - 1);
        check("t3_level_before", btn_level, 1);
        tick(1);
        check("t3_level_after", btn_level, 0);
        check("t3_count", step_count, 2);
        check("t3_pending", q.size(), 0);
        tick(3);

        // 4: auto-repeat at accept, +8, +12, ... then repeat_en=0 stops it.
        repeat_en = 1'b1;
        d = cyc;
        btn_in = 1'b1;
        e = d + LAT;
        push(e);
        for (int t = DELAY; t <= 28; t += PERIOD) push(e + t);
        tick(LAT + 30);
        repeat_en = 1'b0;
        tick(20);
        check("t4_pending", q.size(), 0);
        check("t4_count", step_count, 9);
        check("t4_level", btn_level, 1);
        btn_in = 1'b0;
        tick(LAT + 1);
        check("t4_release", btn_level, 0);

        // 6a: reset mid-DB_PRESS with the button held.
        d = cyc;
        btn_in = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("t6a_pulse", step_pulse, 0);
        check("t6a_level", btn_level, 0);
        check("t6a_count", step_count, 0);
        exp_count = 8'd0;
        rst = 1'b0;
        push(cyc + LAT);
        tick(LAT + 2);
        check("t6a_level_new", btn_level, 1);
        check("t6a_count_new", step_count, 1);
        btn_in = 1'b0;
        tick(LAT + 2);
        check("t6a_pending", q.size(), 0);

        // 6b: reset while in REPEAT, button still held.
        repeat_en = 1'b1;
        d = cyc;
        btn_in = 1'b1;
        e = d + LAT;
        push(e);
        push(e + DELAY);
        tick(LAT + 10);
        rst = 1'b1;
        tick(1);
        check("t6b_pulse", step_pulse, 0);
        check("t6b_level", btn_level, 0);
        check("t6b_count", step_count, 0);
        exp_count = 8'd0;
        rst = 1'b0;
        repeat_en = 1'b0;
        push(cyc + LAT);
        tick(LAT + 3);
        check("t6b_level_new", btn_level, 1);
        check("t6b_count_new", step_count, 1);
        btn_in = 1'b0;
        tick(LAT + 2);
        check("t6b_pending", q.size(), 0);

        // 5: 256 clean presses wrap the count back to 0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_count = 8'd0;
        for (int n = 0; n < 256; n++) begin
            btn_in = 1'b1;
            push(cyc + LAT);
            tick(LAT + 1);
            btn_in = 1'b0;
            tick(LAT + 1);
            if (n == 254) check("t5_count_255", step_count, 255);
        end
        check("t5_wrap", step_count, 0);
        check("t5_level", btn_level, 0);

        tick(10);
        check("final_pending", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
